// File: rtl/uart6551_autobaud.sv
// uart6551_autobaud: automatic baud-rate detector for the uart6551 receive
// path. Once armed it times the low start bit of a character whose LSB is 1,
// picks the standard rate whose nominal bit period is closest to the
// measurement, and reports that rate code with its x16 divisor.
//
// Ports:
//   clk_i   - clock (single domain)
//   rst_ni  - asynchronous active-low reset
//   en_i    - arm detector; low aborts any measurement
//   rxd_i   - raw serial input, asynchronous, idle high
//   busy_o  - high while measuring or searching the rate table
//   done_o  - one-cycle pulse, valid rate found (code_o/div_o updated)
//   err_o   - one-cycle pulse, no rate within tolerance or counter saturated
//   code_o  - detected rate code 1..21 (divisor-table numbering)
//   div_o   - x16 divisor for code_o
module uart6551_autobaud #(
  parameter int unsigned pClkFreq     = 100,
  parameter int unsigned pCounterBits = 24,
  parameter int unsigned pTolShift    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    rxd_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [4:0]              code_o,
  output logic [pCounterBits-1:0] div_o
);

  localparam int unsigned CW = pCounterBits;
  // Clock in units of 0.01 Hz so the fractional rates stay integer.
  localparam logic [63:0] CLK_X100 = 64'(pClkFreq) * 64'd100_000_000;
  localparam logic [CW-1:0] CNT_PRE = {{(CW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, WAIT_HIGH, WAIT_START, MEASURE, SEARCH, RESULT
  } state_t;

  // Baud rate times 100 for each code; zero marks unused codes.
  function automatic logic [31:0] baud_x100(input logic [4:0] k);
    case (k)
      5'd1:    baud_x100 = 32'd5000;
      5'd2:    baud_x100 = 32'd7500;
      5'd3:    baud_x100 = 32'd10992;
      5'd4:    baud_x100 = 32'd13458;
      5'd5:    baud_x100 = 32'd15000;
      5'd6:    baud_x100 = 32'd30000;
      5'd7:    baud_x100 = 32'd60000;
      5'd8:    baud_x100 = 32'd120000;
      5'd9:    baud_x100 = 32'd180000;
      5'd10:   baud_x100 = 32'd240000;
      5'd11:   baud_x100 = 32'd360000;
      5'd12:   baud_x100 = 32'd480000;
      5'd13:   baud_x100 = 32'd720000;
      5'd14:   baud_x100 = 32'd960000;
      5'd15:   baud_x100 = 32'd1920000;
      5'd16:   baud_x100 = 32'd3840000;
      5'd17:   baud_x100 = 32'd5760000;
      5'd18:   baud_x100 = 32'd11520000;
      5'd19:   baud_x100 = 32'd23040000;
      5'd20:   baud_x100 = 32'd46080000;
      5'd21:   baud_x100 = 32'd92160000;
      default: baud_x100 = 32'd0;
    endcase
  endfunction

  // Nominal bit period in clocks, rounded to nearest.
  function automatic logic [CW-1:0] period_of(input logic [31:0] b);
    logic [63:0] q;
    if (b == 32'd0) q = 64'd0;
    else            q = (CLK_X100 + {33'd0, b[31:1]}) / {32'd0, b};
    return q[CW-1:0];
  endfunction

  // x16 divisor, truncated.
  function automatic logic [CW-1:0] divisor_of(input logic [31:0] b);
    logic [63:0] q;
    if (b == 32'd0) q = 64'd0;
    else            q = CLK_X100 / {28'd0, b, 4'd0};
    return q[CW-1:0];
  endfunction

  logic [CW-1:0] per_tab [32];
  logic [CW-1:0] div_tab [32];

  for (genvar g = 0; g < 32; g++) begin : g_tab
    assign per_tab[g] = period_of(baud_x100(5'(g)));
    assign div_tab[g] = divisor_of(baud_x100(5'(g)));
  end

  state_t        state, state_next;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt, meas;
  logic [4:0]    k, best_code;
  logic [CW:0]   best_err, cur_err;
  logic          sat, in_tol, fire_done, fire_err;
  logic [CW-1:0] tol;

  assign rxs = sync[1];

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= 2'b11;
    else         sync <= {sync[0], rxd_i};
  end

  // Distance of the current table entry and tolerance check of the best one.
  always_comb begin
    cur_err = {(CW+1){1'b0}};
    if (meas >= per_tab[k]) cur_err = {1'b0, meas} - {1'b0, per_tab[k]};
    else                    cur_err = {1'b0, per_tab[k]} - {1'b0, meas};
    tol    = per_tab[best_code] >> pTolShift;
    in_tol = (best_err <= {1'b0, tol});
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next state and result pulses.
  always_comb begin
    state_next = state;
    fire_done  = 1'b0;
    fire_err   = 1'b0;
    if (!en_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       state_next = WAIT_HIGH;
        // Only a line seen high first can give a genuine start edge.
        WAIT_HIGH:  if (rxs) state_next = WAIT_START; else state_next = WAIT_HIGH;
        WAIT_START: if (!rxs) state_next = MEASURE; else state_next = WAIT_START;
        MEASURE: begin
          if (rxs)                 state_next = SEARCH;
          else if (cnt == CNT_PRE) state_next = RESULT;  // counter hits all-ones now
          else                     state_next = MEASURE;
        end
        SEARCH:     if (k == 5'd21) state_next = RESULT; else state_next = SEARCH;
        RESULT: begin
          state_next = IDLE;
          if (sat || !in_tol) fire_err  = 1'b1;
          else                fire_done = 1'b1;
        end
        default:    state_next = IDLE;
      endcase
    end
  end

  // Period counter, capture and sequential minimum-error search.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= {CW{1'b0}};
      meas      <= {CW{1'b0}};
      sat       <= 1'b0;
      k         <= 5'd0;
      best_code <= 5'd0;
      best_err  <= {(CW+1){1'b0}};
    end else begin
      case (state)
        WAIT_START: begin
          cnt <= {{(CW-1){1'b0}}, 1'b1};
          sat <= 1'b0;
        end
        MEASURE: begin
          if (rxs) begin
            meas      <= cnt;
            k         <= 5'd1;
            best_code <= 5'd1;
            best_err  <= {(CW+1){1'b1}};
          end else begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            if (cnt == CNT_PRE) sat <= 1'b1;
          end
        end
        SEARCH: begin
          // Strictly smaller only, so ties keep the lower code.
          if (cur_err < best_err) begin
            best_err  <= cur_err;
            best_code <= k;
          end
          k <= k + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; code/div only move on a successful detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      code_o <= 5'd0;
      div_o  <= {CW{1'b0}};
    end else begin
      busy_o <= (state_next == MEASURE) || (state_next == SEARCH);
      done_o <= fire_done;
      err_o  <= fire_err;
      if (fire_done) begin
        code_o <= best_code;
        div_o  <= div_tab[best_code];
      end
    end
  end

endmodule

// File: doc/uart6551_autobaud.md
# uart6551_autobaud

Automatic baud-rate detector for the uart6551 receive path: the inverse of the baud divisor table. When armed, it times the start bit of an incoming character whose LSB is 1 (e.g. CR, 0x0D), compares the measured bit period against the 21 standard rates, and reports the matching rate-select code plus its ×16 divisor. The control register then loads the code in place of a user-programmed selection.

## Interface
- pClkFreq, 100, reference clock in MHz; the nominal table is computed from it at elaboration.
- pCounterBits, 24, width of the period counter and of div_o; must hold the 50-baud period (2,000,000 at 100 MHz).
- pTolShift, 3, match tolerance = nominal period >> pTolShift (12.5 %).
- clk_i  input  1  clock; one clock domain.
- rst_ni  input  1  reset, asynchronous, active-low.
- en_i  input  1  arm detector; low aborts any measurement.
- rxd_i  input  1  raw serial input, asynchronous; idle high.
- busy_o  output  1  high in MEASURE and SEARCH.
- done_o  output  1  one-cycle pulse: valid rate found.
- err_o  output  1  one-cycle pulse: no rate within tolerance, or counter saturated.
- code_o  output  5  detected rate code, 1..21; same code numbering as the divisor table.
- div_o  output  pCounterBits  ×16 divisor for code_o = floor(pClkFreq·1e6 / (16·baud)).

## Operation
- rxd_i passes through a 2-flop synchroniser; all logic uses the synchronised value (rxs).
- Nominal bit period per code: P[k] = round(pClkFreq·1e6 / baud[k]), with baud = 50, 75, 109.92, 134.58, 150, 300, 600, 1200, 1800, 2400, 3600, 4800, 7200, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600 for k = 1..21.
- States:
  - IDLE → WAIT_HIGH when en_i = 1.
  - WAIT_HIGH → WAIT_START when rxs = 1. This rejects a line already low, e.g. a break.
  - WAIT_START → MEASURE on rxs = 0. The counter loads 1.
  - MEASURE: counter increments each cycle while rxs = 0.
    - On rxs = 1, capture meas → SEARCH.
    - If the counter reaches all-ones with rxs still 0 → RESULT(err).
  - SEARCH: one code per cycle, k = 1..21 (21 cycles).
    - err = |meas − P[k]|, computed in pCounterBits+1 bits.
    - A candidate replaces the current best only if its err is strictly smaller; ties keep the lower code.
    - After k = 21 → RESULT.
  - RESULT (1 cycle):
    - If best err ≤ P[best] >> pTolShift: pulse done_o and load code_o and div_o.
    - Otherwise pulse err_o; code_o and div_o are unchanged.
    - Next state → IDLE, which re-arms immediately if en_i is still high.
- en_i = 0 in any state forces IDLE on the next edge. No pulse is emitted and outputs are unchanged.
- The counter never wraps; saturation is an error.

## Timing
- Reset values: state IDLE; busy_o, done_o, err_o, code_o, div_o all 0; synchroniser flops 1.
- Both edges are delayed equally by the synchroniser, so meas equals the low time at the pin in clk cycles (±1).
- Latency, rising edge of rxs to done_o/err_o: 1 cycle into SEARCH + 21 search cycles + RESULT = done_o asserted on the 23rd edge after rxs rises.
- Saturation error: err_o on the edge after the counter reaches all-ones.
- code_o and div_o change only on the done_o cycle and hold until the next success.
- done_o and err_o are mutually exclusive and never asserted in consecutive cycles from one measurement.

## Test plan
- pClkFreq=100; 9600-baud CR frame, start bit low 10417 cycles → done_o once, code_o=14, div_o=651, ~23 cycles after rxd rises.
- 115200-baud CR frame (868 cycles low) → code_o=18, div_o=54; then 150 baud (666667 cycles) → code_o=5, div_o=41666. Confirms 134.58 (P=743052) is rejected by min-error selection.
- Low pulse of 6000 cycles → err_o pulse; code_o and div_o keep their previous values.
- rxd_i held low from arm → stays in WAIT_HIGH with no pulse; release, then 868-cycle pulse → code_o=18.
- rxd_i held low for more than 2^24 cycles after a falling edge → single err_o at saturation; no done_o until the line goes high and a new valid start bit arrives.
- Drop en_i mid-MEASURE, and separately assert rst_ni low mid-SEARCH → no done_o/err_o. Reset clears code_o and div_o to 0 asynchronously; the en_i drop leaves them unchanged.
